// File: rtl/tap_delay_sequencer.sv
// Tap-delay sequencer: holds the last NTAPS input samples in a circular
// buffer. For each accepted sample it streams the delayed samples x[n-k],
// k = 0..NTAPS-1, over a valid/ready handshake to a shared MAC.
module tap_delay_sequencer #(
    parameter  int NTAPS = 16,
    parameter  int W     = 32,
    localparam int AW    = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_valid,
    input  logic [W-1:0]  sample_in,
    output logic          sample_ready,
    output logic          tap_valid,
    output logic [W-1:0]  tap_data,
    output logic [AW-1:0] tap_idx,
    output logic          tap_last,
    input  logic          tap_ready,
    output logic          busy,
    output logic          overrun,
    input  logic          clr_overrun
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t        state_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] k_q;
    logic          tap_valid_q;
    logic [W-1:0]  tap_data_q;
    logic          tap_last_q;
    logic          overrun_q;
    logic [W-1:0]  buf_q [NTAPS];

    logic          accept;
    logic          xfer;
    logic [AW-1:0] k_d;
    logic [AW-1:0] rd_addr;
    logic          last_d;

    // Handshake decode and address of the tap that follows the current one
    always_comb begin
        accept  = (state_q == IDLE) && sample_valid;
        xfer    = tap_valid_q && tap_ready;
        k_d     = k_q + 1'b1;
        rd_addr = wr_ptr_q - k_d;
        last_d  = (k_d == AW'(NTAPS - 1));
    end

    // Circular sample buffer: each entry is written only when a sample is
    // accepted and the write pointer addresses it; reset clears every entry
    // so the first bursts after reset see zero history.
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_buf
            // Storage for buffer slot gi
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    buf_q[gi] <= '0;
                end else if (accept && (wr_ptr_q == AW'(gi))) begin
                    buf_q[gi] <= sample_in;
                end
            end
        end
    endgenerate

    // Burst sequencer: accepts a sample in IDLE, then walks k through all
    // taps in STREAM. The k=0 tap is taken straight from sample_in, since the
    // buffer write happens on the same edge and is not yet readable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            k_q         <= '0;
            tap_valid_q <= 1'b0;
            tap_data_q  <= '0;
            tap_last_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sample_valid) begin
                        state_q     <= STREAM;
                        k_q         <= '0;
                        tap_valid_q <= 1'b1;
                        tap_data_q  <= sample_in;
                        tap_last_q  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        k_q        <= k_d;
                        tap_data_q <= buf_q[rd_addr];
                        tap_last_q <= last_d;
                        if (tap_last_q) begin
                            state_q     <= IDLE;
                            tap_valid_q <= 1'b0;
                            wr_ptr_q    <= wr_ptr_q + 1'b1;
                        end
                    end
                end
            endcase

            // A sample offered mid-burst is dropped and flagged; the set
            // wins over a simultaneous clear so no event is lost.
            if ((state_q == STREAM) && sample_valid) begin
                overrun_q <= 1'b1;
            end else if (clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign sample_ready = (state_q == IDLE);
    assign busy         = (state_q == STREAM);
    assign tap_valid    = tap_valid_q;
    assign tap_data     = tap_data_q;
    assign tap_idx      = k_q;
    assign tap_last     = tap_last_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tap_delay_sequencer.sv
// Bench for tap_delay_sequencer (NTAPS=4, W=32). The reference model keeps a
// queue of every accepted sample since reset; tap k of a burst is simply the
// k-th most recent accepted sample, or zero if history is that short.
module tb_tap_delay_sequencer;

    localparam int NTAPS = 4;
    localparam int W     = 32;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sample_valid;
    logic [W-1:0]  sample_in;
    logic          sample_ready;
    logic          tap_valid;
    logic [W-1:0]  tap_data;
    logic [AW-1:0] tap_idx;
    logic          tap_last;
    logic          tap_ready;
    logic          busy;
    logic          overrun;
    logic          clr_overrun;

    tap_delay_sequencer #(.NTAPS(NTAPS), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .tap_valid    (tap_valid),
        .tap_data     (tap_data),
        .tap_idx      (tap_idx),
        .tap_last     (tap_last),
        .tap_ready    (tap_ready),
        .busy         (busy),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun)
    );

    always #5 clk = ~clk;

    int          total  = 0;
    int          passed = 0;
    int          fails  = 0;
    logic [31:0] hist[$];
    logic        ov_exp = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_tap(input int k);
        if (k < hist.size()) return hist[hist.size() - 1 - k];
        return 32'h0;
    endfunction

    // One full burst; optional stall at tap stall_k for stall_n cycles and
    // optional overrun injection (with or without a same-cycle clear) at k=1.
    task automatic burst(input logic [31:0] s, input int stall_k, input int stall_n,
                         input bit inj, input bit clr_same);
        int cyc;
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = sample_ready;
        end
        check("ready_before_burst", {31'b0, sample_ready}, 32'd1);
        sample_valid = 1'b1;
        sample_in    = s;
        tap_ready    = 1'b1;
        hist.push_back(s);
        cyc = 0;
        @(negedge clk);
        cyc++;
        sample_valid = 1'b0;
        sample_in    = 32'h0;
        for (int k = 0; k < NTAPS; k++) begin
            if (k == stall_k) begin
                for (int j = 0; j < stall_n; j++) begin
                    tap_ready = 1'b0;
                    check("stall_valid", {31'b0, tap_valid}, 32'd1);
                    check("stall_data", tap_data, exp_tap(k));
                    check("stall_idx", {30'b0, tap_idx}, 32'(k));
                    @(negedge clk);
                    cyc++;
                end
            end
            tap_ready = 1'b1;
            check("tap_valid", {31'b0, tap_valid}, 32'd1);
            check("tap_data", tap_data, exp_tap(k));
            check("tap_idx", {30'b0, tap_idx}, 32'(k));
            check("tap_last", {31'b0, tap_last}, (k == NTAPS - 1) ? 32'd1 : 32'd0);
            check("busy_in_burst", {31'b0, busy}, 32'd1);
            check("not_ready_in_burst", {31'b0, sample_ready}, 32'd0);
            if (inj && k == 1) begin
                sample_valid = 1'b1;
                sample_in    = 32'hFFFF_FFFF;
                clr_overrun  = clr_same;
                ov_exp       = 1'b1;
            end
            @(negedge clk);
            cyc++;
            sample_valid = 1'b0;
            sample_in    = 32'h0;
            clr_overrun  = 1'b0;
        end
        check("valid_drop", {31'b0, tap_valid}, 32'd0);
        check("busy_drop", {31'b0, busy}, 32'd0);
        check("ready_back", {31'b0, sample_ready}, 32'd1);
        check("burst_cycles", 32'(cyc), 32'(NTAPS + 1 + stall_n));
        check("overrun_after_burst", {31'b0, overrun}, {31'b0, ov_exp});
    endtask

    task automatic clear_ov();
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        ov_exp      = 1'b0;
        check("overrun_cleared", {31'b0, overrun}, 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 32'h0;
        tap_ready    = 1'b0;
        clr_overrun  = 1'b0;
        #1;
        check("rst_ready", {31'b0, sample_ready}, 32'd1);
        check("rst_valid", {31'b0, tap_valid}, 32'd0);
        check("rst_data", tap_data, 32'd0);
        check("rst_idx", {30'b0, tap_idx}, 32'd0);
        check("rst_last", {31'b0, tap_last}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // tap_ready with nothing in flight must not start anything
        tap_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_valid", {31'b0, tap_valid}, 32'd0);
            check("idle_ready", {31'b0, sample_ready}, 32'd1);
        end

        // First burst after reset: only k=0 is non-zero
        burst(32'h0000_0005, -1, 0, 1'b0, 1'b0);

        // Sequential samples wrap the write pointer
        for (int s = 1; s <= 5; s++) burst(32'(s), -1, 0, 1'b0, 1'b0);

        // Backpressure at k=1 for 3 cycles
        burst(32'h0000_0006, 1, 3, 1'b0, 1'b0);

        // Dropped sample sets a sticky overrun; taps unaffected
        burst(32'h0000_0007, -1, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("overrun_sticky", {31'b0, overrun}, 32'd1);
        end
        clear_ov();

        // Set wins over a simultaneous clear
        burst(32'h0000_0008, -1, 0, 1'b1, 1'b1);
        clear_ov();

        // Reset in the middle of a burst at k=2
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = 32'h1234_5678;
        tap_ready    = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_idx", {30'b0, tap_idx}, 32'd2);
        rst = 1'b1;
        #1;
        check("midrst_valid", {31'b0, tap_valid}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_data", tap_data, 32'd0);
        hist.delete();
        ov_exp = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_no_taps", {31'b0, tap_valid}, 32'd0);
        end
        burst(32'h8000_0000, -1, 0, 1'b0, 1'b0);

        // Randomized bursts with random stalls and overrun events
        for (int n = 0; n < 24; n++) begin
            int  sk;
            int  sn;
            bit  inj;
            bit  cs;
            sk  = int'($urandom_range(0, 3));
            sn  = int'($urandom_range(0, 3));
            inj = ($urandom_range(0, 3) == 0);
            cs  = $urandom_range(0, 1) == 1;
            burst($urandom, sk, sn, inj, cs);
            if (ov_exp && ($urandom_range(0, 1) == 1)) clear_ov();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
